// File: rtl/ddr3_bus_pkg.sv
// ============================================================================
// ddr3_bus_pkg : shared widths, request struct and round-robin helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package ddr3_bus_pkg;

  localparam int ADDR_WIDTH    = 24;
  localparam int DATA_WIDTH    = 128;
  localparam int BYTE_EN_WIDTH = 16;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic                     write;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [BYTE_EN_WIDTH-1:0] write_byte_enable;
  } bus_req_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_bus_arbiter_id_fifo.sv
// ============================================================================
// ddr3_bus_arbiter_id_fifo : synchronous FIFO of requester IDs for read routing
// Revision: 1.0
// ============================================================================
`default_nettype none

module ddr3_bus_arbiter_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Flags come from the registered count only, so a same-cycle pop never frees a slot
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ddr3_bus_arbiter.sv
// ============================================================================
// ddr3_bus_arbiter : round-robin sharing of one Buster port with in-order read
// routing. Optional counters under macro DDR3_BUS_ARBITER_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ddr3_bus_arbiter
  import ddr3_bus_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int ID_FIFO_DEPTH  = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_REQUESTERS-1:0]               req_enable,
  input  logic [ADDR_WIDTH*NUM_REQUESTERS-1:0]    req_addr,
  input  logic [NUM_REQUESTERS-1:0]               req_write,
  input  logic [DATA_WIDTH*NUM_REQUESTERS-1:0]    req_write_data,
  input  logic [BYTE_EN_WIDTH*NUM_REQUESTERS-1:0] req_write_byte_enable,
  output logic [NUM_REQUESTERS-1:0]               req_ready,
  output logic [DATA_WIDTH-1:0]                   req_read_data,
  output logic [NUM_REQUESTERS-1:0]               req_read_data_valid,
  output logic                                    bus_enable,
  output logic [ADDR_WIDTH-1:0]                   bus_addr,
  output logic                                    bus_write,
  output logic [DATA_WIDTH-1:0]                   bus_write_data,
  output logic [BYTE_EN_WIDTH-1:0]                bus_write_byte_enable,
  input  logic                                    bus_ready,
  input  logic [DATA_WIDTH-1:0]                   bus_read_data,
  input  logic                                    bus_read_data_valid,
`ifdef DDR3_BUS_ARBITER_STATS_EN
  output logic [32*NUM_REQUESTERS-1:0]            grant_count,
  output logic [32*NUM_REQUESTERS-1:0]            stall_count,
`endif
  output logic                                    read_route_error
);

  localparam int IDW = $clog2(NUM_REQUESTERS);

  bus_req_t                  reqs [NUM_REQUESTERS];
  bus_req_t                  sel_req;
  logic [NUM_REQUESTERS-1:0] eligible;
  logic [IDW-1:0]            sel;
  logic [IDW-1:0]            rr_ptr;
  logic [IDW-1:0]            head;
  logic                      any_elig;
  logic                      accept;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  int                        idx;

  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_unpack
    assign reqs[i] = {req_addr[ADDR_WIDTH*i +: ADDR_WIDTH],
                      req_write[i],
                      req_write_data[DATA_WIDTH*i +: DATA_WIDTH],
                      req_write_byte_enable[BYTE_EN_WIDTH*i +: BYTE_EN_WIDTH]};
    assign eligible[i] = req_enable[i] & (req_write[i] | ~fifo_full);
  end

  // Selection deliberately ignores bus_ready to avoid a loop through the bridge
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQUESTERS;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        sel      = IDW'(idx);
      end
    end
  end

  assign sel_req               = any_elig ? reqs[sel] : '0;
  assign bus_enable            = any_elig;
  assign bus_addr              = sel_req.addr;
  assign bus_write             = sel_req.write;
  assign bus_write_data        = sel_req.write_data;
  assign bus_write_byte_enable = sel_req.write_byte_enable;
  assign accept                = any_elig & bus_ready;
  assign push                  = accept & ~sel_req.write;
  assign pop                   = bus_read_data_valid & ~fifo_empty;
  assign req_read_data         = bus_read_data;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[sel] = 1'b1;
    end
  end

  always_comb begin
    req_read_data_valid = '0;
    if (pop) begin
      req_read_data_valid[head] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr           <= '0;
      read_route_error <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= IDW'(rr_next(int'(sel), NUM_REQUESTERS));
      end
      if (bus_read_data_valid && fifo_empty) begin
        read_route_error <= 1'b1;
      end
    end
  end

  ddr3_bus_arbiter_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (sel),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef DDR3_BUS_ARBITER_STATS_EN
  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_stats
    logic [31:0] grants;
    logic [31:0] stalls;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        grants <= '0;
        stalls <= '0;
      end else begin
        if (req_ready[i]) begin
          grants <= grants + 32'd1;
        end
        if (req_enable[i] && !req_ready[i]) begin
          stalls <= stalls + 32'd1;
        end
      end
    end

    assign grant_count[32*i +: 32] = grants;
    assign stall_count[32*i +: 32] = stalls;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr3_bus_arbiter.sv
// ============================================================================
// tb_ddr3_bus_arbiter : directed and random stimulus against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ddr3_bus_arbiter;

  localparam int N     = 2;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_enable;
  logic [24*N-1:0]  req_addr;
  logic [N-1:0]     req_write;
  logic [128*N-1:0] req_write_data;
  logic [16*N-1:0]  req_write_byte_enable;
  logic [N-1:0]     req_ready;
  logic [127:0]     req_read_data;
  logic [N-1:0]     req_read_data_valid;
  logic             bus_enable;
  logic [23:0]      bus_addr;
  logic             bus_write;
  logic [127:0]     bus_write_data;
  logic [15:0]      bus_write_byte_enable;
  logic             bus_ready;
  logic [127:0]     bus_read_data;
  logic             bus_read_data_valid;
  logic             read_route_error;
`ifdef DDR3_BUS_ARBITER_STATS_EN
  logic [32*N-1:0]  grant_count;
  logic [32*N-1:0]  stall_count;
`endif

  ddr3_bus_arbiter #(.NUM_REQUESTERS(N), .ID_FIFO_DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_enable            (req_enable),
    .req_addr              (req_addr),
    .req_write             (req_write),
    .req_write_data        (req_write_data),
    .req_write_byte_enable (req_write_byte_enable),
    .req_ready             (req_ready),
    .req_read_data         (req_read_data),
    .req_read_data_valid   (req_read_data_valid),
    .bus_enable            (bus_enable),
    .bus_addr              (bus_addr),
    .bus_write             (bus_write),
    .bus_write_data        (bus_write_data),
    .bus_write_byte_enable (bus_write_byte_enable),
    .bus_ready             (bus_ready),
    .bus_read_data         (bus_read_data),
    .bus_read_data_valid   (bus_read_data_valid),
`ifdef DDR3_BUS_ARBITER_STATS_EN
    .grant_count           (grant_count),
    .stall_count           (stall_count),
`endif
    .read_route_error      (read_route_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: next-priority index, outstanding-read owner queue, sticky error
  int rr;
  int owners[$];
  bit err;

  logic [N-1:0] seen_ready;
  logic [N-1:0] seen_rdv;
  logic         seen_en;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_enable            = '0;
    req_write             = '0;
    req_addr              = '0;
    req_write_data        = '0;
    req_write_byte_enable = '0;
    bus_ready             = 1'b0;
    bus_read_data         = '0;
    bus_read_data_valid   = 1'b0;
  endtask

  task automatic set_req(input int i, input bit en, input bit wr, input logic [23:0] a,
                         input logic [127:0] d, input logic [15:0] be);
    req_enable[i]                    = en;
    req_write[i]                     = wr;
    req_addr[24*i +: 24]             = a;
    req_write_data[128*i +: 128]     = d;
    req_write_byte_enable[16*i +: 16] = be;
  endtask

  // Called at a falling edge with inputs set; checks outputs, then advances one clock
  task automatic step();
    bit           any;
    int           sel;
    int           i;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rdv;
    #1;
    any = 1'b0;
    sel = 0;
    for (int k = 0; k < N; k++) begin
      i = (rr + k) % N;
      if (!any && req_enable[i] && (req_write[i] || owners.size() < DEPTH)) begin
        any = 1'b1;
        sel = i;
      end
    end
    exp_ready = '0;
    if (any && bus_ready) exp_ready[sel] = 1'b1;
    exp_rdv = '0;
    if (bus_read_data_valid && owners.size() > 0) exp_rdv[owners[0]] = 1'b1;

    check("bus_enable", bus_enable, any);
    check("bus_addr", bus_addr, any ? req_addr[24*sel +: 24] : 24'h0);
    check("bus_write", bus_write, any ? req_write[sel] : 1'b0);
    check("bus_wdata", bus_write_data, any ? req_write_data[128*sel +: 128] : 128'h0);
    check("bus_be", bus_write_byte_enable, any ? req_write_byte_enable[16*sel +: 16] : 16'h0);
    check("req_ready", req_ready, exp_ready);
    check("rd_valid", req_read_data_valid, exp_rdv);
    check("rd_data", req_read_data, bus_read_data);
    check("route_err", read_route_error, err);
    seen_ready = req_ready;
    seen_rdv   = req_read_data_valid;
    seen_en    = bus_enable;

    @(posedge clk);
    if (bus_read_data_valid) begin
      if (owners.size() > 0) void'(owners.pop_front());
      else err = 1'b1;
    end
    if (any && bus_ready) begin
      rr = (sel + 1) % N;
      if (!req_write[sel]) owners.push_back(sel);
    end
    @(negedge clk);
  endtask

  // Asserted away from any clock edge so the asynchronous clear is exercised
  task automatic apply_reset();
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    rr = 0;
    owners.delete();
    err = 1'b0;
    check("rst_err", read_route_error, 1'b0);
    check("rst_en", bus_enable, 1'b0);
    check("rst_ready", req_ready, '0);
    check("rst_rdv", req_read_data_valid, '0);
    check("rst_addr", bus_addr, 24'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    apply_reset();

    // Two continuous writers alternate grants
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1, 1, 24'h000100 + 24'(c), {4{$urandom}}, 16'hFFFF);
      set_req(1, 1, 1, 24'h000200 + 24'(c), {4{$urandom}}, 16'h00FF);
      bus_ready = 1'b1;
      step();
      check("alt_grant", seen_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Two reads, returned in order to their owners
    set_req(0, 1, 0, 24'h000010, '0, '0);
    set_req(1, 1, 0, 24'h000020, '0, '0);
    step();
    check("rd0_grant", seen_ready, 2'b01);
    req_enable = 2'b10;
    step();
    check("rd1_grant", seen_ready, 2'b10);
    idle_inputs();
    bus_read_data = 128'hD0D0_D0D0;
    bus_read_data_valid = 1'b1;
    step();
    check("ret_d0", seen_rdv, 2'b01);
    bus_read_data = 128'hD1D1_D1D1;
    step();
    check("ret_d1", seen_rdv, 2'b10);

    // Fill the ID FIFO from R0; the 17th read waits while R1 writes proceed
    apply_reset();
    for (int c = 0; c < DEPTH; c++) begin
      idle_inputs();
      set_req(0, 1, 0, 24'(c), '0, '0);
      bus_ready = 1'b1;
      step();
    end
    set_req(1, 1, 1, 24'h0ABCDE, 128'h55, 16'h1);
    step();
    check("full_hold", seen_ready, 2'b10);
    req_enable = 2'b01;
    bus_read_data_valid = 1'b1;
    bus_read_data = 128'h1234;
    step();
    check("full_pop_hold", seen_ready, 2'b00);
    check("full_pop_rdv", seen_rdv, 2'b01);
    bus_read_data_valid = 1'b0;
    step();
    check("full_release", seen_ready, 2'b01);
    idle_inputs();
    bus_read_data_valid = 1'b1;
    for (int c = 0; c < DEPTH; c++) step();
    bus_read_data_valid = 1'b0;

    // Backpressure: R1 waits with bus_ready low, granted once it rises
    set_req(1, 1, 1, 24'h000777, 128'hAB, 16'hF0F0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_enable", seen_en, 1'b1);
      check("bp_ready", seen_ready, 2'b00);
    end
    bus_ready = 1'b1;
    step();
    check("bp_grant", seen_ready, 2'b10);

    // Return with nothing outstanding, then async reset with reads in flight
    idle_inputs();
    bus_read_data_valid = 1'b1;
    step();
    check("orphan_rdv", seen_rdv, 2'b00);
    bus_read_data_valid = 1'b0;
    step();
    check("err_sticky", read_route_error, 1'b1);
    set_req(0, 1, 0, 24'h000033, '0, '0);
    bus_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    apply_reset();
    bus_read_data_valid = 1'b1;
    step();
    check("post_rst_rdv", seen_rdv, 2'b00);
    bus_read_data_valid = 1'b0;
    step();

`ifdef DDR3_BUS_ARBITER_STATS_EN
    apply_reset();
    set_req(0, 1, 1, 24'h000001, 128'h1, 16'h1);
    bus_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    bus_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("grant_cnt0", grant_count[31:0], 32'd10);
    check("stall_cnt0", stall_count[31:0], 32'd3);
    check("grant_cnt1", grant_count[63:32], 32'd0);
`endif

    // Random traffic
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < N; r++) begin
        set_req(r, ($urandom % 3) != 0, $urandom % 2, 24'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
      end
      bus_ready           = ($urandom % 4) != 0;
      bus_read_data       = {$urandom, $urandom, $urandom, $urandom};
      bus_read_data_valid = (owners.size() > 0) && (($urandom % 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ddr3_bus_arbiter.md
Name: ddr3_bus_arbiter

Overview:
- Shares one Buster bus port (into the MIG UI bridge, 128-bit data, 24-bit word address) between NUM_REQUESTERS masters.
- Round-robin arbitration, one single-beat transaction per accepted cycle.
- Read responses return downstream in order; a requester-ID FIFO routes each response back to its originator.
- Sits between test/traffic masters and the bridge, clocked in the ~100 MHz ui clock domain.

Parameters:
- NUM_REQUESTERS, 2, number of upstream masters (2..8).
- ID_FIFO_DEPTH, 16, max outstanding reads tracked (power of two, >= 2).

Ports:
- clk  in  1  ui clock.
- reset  in  1  asynchronous, active-high reset.
- req_enable  in  NUM_REQUESTERS  per-requester transaction valid.
- req_addr  in  24*NUM_REQUESTERS  packed word addresses, requester i at [24*i +: 24].
- req_write  in  NUM_REQUESTERS  1 = write, 0 = read.
- req_write_data  in  128*NUM_REQUESTERS  packed write data.
- req_write_byte_enable  in  16*NUM_REQUESTERS  packed byte enables.
- req_ready  out  NUM_REQUESTERS  accept strobe; transaction i is taken when req_enable[i] & req_ready[i].
- req_read_data  out  128  shared read data, broadcast to all requesters.
- req_read_data_valid  out  NUM_REQUESTERS  one-hot read-return strobe.
- bus_enable  out  1  downstream valid.
- bus_addr  out  24  downstream word address.
- bus_write  out  1  downstream write flag.
- bus_write_data  out  128  downstream write data.
- bus_write_byte_enable  out  16  downstream byte enables.
- bus_ready  in  1  downstream accept.
- bus_read_data  in  128  downstream read data.
- bus_read_data_valid  in  1  downstream read strobe.
- read_route_error  out  1  sticky: a read return arrived with no tracked owner.

Behaviour:
- Clocking/reset: one clock. Reset is asynchronous, active-high. All registers clear on reset.
- Eligibility: requester i is eligible iff req_enable[i] & (req_write[i] | ~id_fifo_full). Writes are never blocked by the FIFO.
- Selection (combinational):
  - The first eligible requester scanning from rr_ptr upward, modulo NUM_REQUESTERS.
  - Selection must NOT depend on bus_ready (no combinational loop through the bridge).
- Forwarding (zero latency):
  - bus_enable = any eligible.
  - bus_addr, bus_write, bus_write_data and bus_write_byte_enable are muxed from the selected requester.
  - When nothing is eligible, all of these are 0.
- Ready: req_ready[sel] = bus_ready & bus_enable; all other bits are 0.
- rr_ptr:
  - Reset value 0.
  - On an accepted transaction, rr_ptr <= (sel + 1) mod NUM_REQUESTERS; otherwise it holds.
- ID FIFO:
  - Width clog2(NUM_REQUESTERS), depth ID_FIFO_DEPTH.
  - Push sel on an accepted read.
  - Pop on bus_read_data_valid.
  - Full flag uses the registered count only. A pop in the same cycle does not unblock reads; that is deliberate, for timing.
  - Simultaneous push and pop when not full: count is unchanged, and both happen.
- Read return:
  - req_read_data = bus_read_data, passed through combinationally.
  - req_read_data_valid[head] = bus_read_data_valid when the FIFO is non-empty.
- Empty-FIFO return:
  - bus_read_data_valid while the FIFO is empty sets read_route_error (sticky until reset).
  - No strobe is emitted and there is no pop.
- Reset values: rr_ptr = 0, FIFO count = 0, read_route_error = 0. All combinational outputs are 0 with no requests.
- Reset mid-operation:
  - Outstanding IDs are discarded.
  - The bridge must be reset together with this block; otherwise late returns flag read_route_error.
- Wrap-around: FIFO pointers wrap modulo ID_FIFO_DEPTH; the count saturates logic at full via eligibility.

Optional Feature:
- Macro: DDR3_BUS_ARBITER_STATS_EN.
- When defined, adds these outputs:
  - grant_count, 32*NUM_REQUESTERS: accepted transactions per requester.
  - stall_count, 32*NUM_REQUESTERS: cycles with req_enable[i] & ~req_ready[i].
  - Both wrap at 2^32 and clear on reset.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package ddr3_bus_pkg holds:
  - ADDR_WIDTH = 24, DATA_WIDTH = 128, BYTE_EN_WIDTH = 16.
  - Typedef bus_req_t {addr, write, write_data, write_byte_enable}.
  - Function for the round-robin next index.
- One sub-module: ddr3_bus_arbiter_id_fifo, a synchronous FIFO with full/empty flags and async reset.

Test Plan:
- Both requesters write continuously, bus_ready = 1 -> grants alternate 0,1,0,1 for 8 cycles; bus_addr follows each requester's address sequence.
- R0 reads addr 0x000010, R1 reads addr 0x000020, then the bridge returns D0, D1 -> req_read_data_valid = 2'b01 with D0, then 2'b10 with D1.
- 16 reads from R0 outstanding, none returned -> FIFO is full and R0's 17th read is held (req_ready[0] = 0), while an R1 write is still granted; after one return, the held read is accepted the following cycle.
- bus_ready held 0 for 5 cycles with R1 requesting -> bus_enable = 1, req_ready = 0 throughout, rr_ptr unchanged; the grant lands on the first cycle bus_ready = 1.
- bus_read_data_valid pulsed with an empty FIFO -> read_route_error rises and stays 1; there is no req_read_data_valid; async reset mid-burst clears it and the FIFO immediately.
- With DDR3_BUS_ARBITER_STATS_EN: 10 R0 grants plus 3 stall cycles -> grant_count[0] = 10, stall_count[0] = 3.
